// File: rtl/maq_pkg.sv
// Shared BCD digit types and digit limits for the minutes/seconds counter.
package maq_pkg;

    typedef logic [3:0] bcd_t;
    typedef logic [2:0] bcd6_t;

    localparam bcd_t  BCD_LSD_MAX  = 4'd9;
    localparam bcd6_t BCD6_MSD_MAX = 3'd5;

endpackage

// File: rtl/maq_bcd60.sv
// Two-digit BCD counter 00..59. The clear input wins over the increment input.
// wrap flags an increment taken while the count is 59.
module maq_bcd60
    import maq_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] lsd,
    output logic [2:0] msd,
    output logic       wrap
);

    bcd_t  lsd_q;
    bcd6_t msd_q;

    // reset is active low, matching the top-level reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lsd_q <= '0;
            msd_q <= '0;
        end else if (clr) begin
            lsd_q <= '0;
            msd_q <= '0;
        end else if (inc) begin
            if (lsd_q == BCD_LSD_MAX) begin
                lsd_q <= '0;
                if (msd_q == BCD6_MSD_MAX) begin
                    msd_q <= '0;
                end else begin
                    msd_q <= msd_q + 3'd1;
                end
            end else begin
                lsd_q <= lsd_q + 4'd1;
            end
        end
    end

    assign wrap = inc && (lsd_q == BCD_LSD_MAX) && (msd_q == BCD6_MSD_MAX);
    assign lsd  = lsd_q;
    assign msd  = msd_q;

endmodule

// File: rtl/maq_ms.sv
// Minutes/seconds stage: 1 Hz prescaler, BCD seconds and minutes, manual minute
// set while stopped, seconds clear, and a registered hour-carry strobe.
module maq_ms
    import maq_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int PRE_W  = $clog2(CLK_HZ)
) (
    input  logic       maq_ms_clock,
    input  logic       maq_ms_reset,
    input  logic       maq_ms_run,
    input  logic       maq_ms_set_min,
    input  logic       maq_ms_clr_sec,
    output logic [3:0] maq_ms_sec_lsd,
    output logic [2:0] maq_ms_sec_msd,
    output logic [3:0] maq_ms_min_lsd,
    output logic [2:0] maq_ms_min_msd,
    output logic       maq_ms_tick_1hz,
    output logic       maq_ms_hour_carry
);

    logic [PRE_W-1:0] pre;
    logic             tick;
    logic             set_s1;
    logic             set_s2;
    logic             set_hist;
    logic             set_accept;
    logic             sec_wrap;
    logic             min_wrap;
    logic             min_inc;
    logic             tick_q;
    logic             carry_q;

    assign tick = (pre == PRE_W'(CLK_HZ - 1)) && maq_ms_run && !maq_ms_clr_sec;

    always_ff @(posedge maq_ms_clock or negedge maq_ms_reset) begin
        if (!maq_ms_reset) begin
            pre <= '0;
        end else if (maq_ms_clr_sec || tick) begin
            pre <= '0;
        end else if (maq_ms_run) begin
            pre <= pre + PRE_W'(1);
        end
    end

    // Flops reset high so a button held through reset release is not seen as a press.
    always_ff @(posedge maq_ms_clock or negedge maq_ms_reset) begin
        if (!maq_ms_reset) begin
            set_s1   <= 1'b1;
            set_s2   <= 1'b1;
            set_hist <= 1'b1;
        end else begin
            set_s1   <= maq_ms_set_min;
            set_s2   <= set_s1;
            set_hist <= set_s2;
        end
    end

    assign set_accept = set_s2 && !set_hist && !maq_ms_run;
    assign min_inc    = sec_wrap || set_accept;

    maq_bcd60 u_sec (
        .clock (maq_ms_clock),
        .reset (maq_ms_reset),
        .inc   (tick),
        .clr   (maq_ms_clr_sec),
        .lsd   (maq_ms_sec_lsd),
        .msd   (maq_ms_sec_msd),
        .wrap  (sec_wrap)
    );

    maq_bcd60 u_min (
        .clock (maq_ms_clock),
        .reset (maq_ms_reset),
        .inc   (min_inc),
        .clr   (1'b0),
        .lsd   (maq_ms_min_lsd),
        .msd   (maq_ms_min_msd),
        .wrap  (min_wrap)
    );

    // A manual minute wrap never reaches the hours stage; only a seconds carry does.
    always_ff @(posedge maq_ms_clock or negedge maq_ms_reset) begin
        if (!maq_ms_reset) begin
            tick_q  <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            tick_q  <= tick;
            carry_q <= sec_wrap && min_wrap;
        end
    end

    assign maq_ms_tick_1hz   = tick_q;
    assign maq_ms_hour_carry = carry_q;

endmodule

// File: tb/tb_maq_ms.sv
// Directed self-checking bench for maq_ms with a 4-cycle second.
module tb_maq_ms;

    logic       clock;
    logic       reset;
    logic       run;
    logic       set_min;
    logic       clr_sec;
    logic [3:0] sec_lsd;
    logic [2:0] sec_msd;
    logic [3:0] min_lsd;
    logic [2:0] min_msd;
    logic       tick_1hz;
    logic       hour_carry;

    int errors = 0;
    int checks = 0;
    int carry_seen = 0;

    maq_ms #(.CLK_HZ(4)) dut (
        .maq_ms_clock      (clock),
        .maq_ms_reset      (reset),
        .maq_ms_run        (run),
        .maq_ms_set_min    (set_min),
        .maq_ms_clr_sec    (clr_sec),
        .maq_ms_sec_lsd    (sec_lsd),
        .maq_ms_sec_msd    (sec_msd),
        .maq_ms_min_lsd    (min_lsd),
        .maq_ms_min_msd    (min_msd),
        .maq_ms_tick_1hz   (tick_1hz),
        .maq_ms_hour_carry (hour_carry)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [7:0] sec_bcd();
        return {1'b0, sec_msd, sec_lsd};
    endfunction

    function automatic logic [7:0] min_bcd();
        return {1'b0, min_msd, min_lsd};
    endfunction

    task automatic check_output(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
            $error("[TB] %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Sample 1 time unit after each rising edge, away from the active edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
            if (hour_carry) carry_seen++;
        end
    endtask

    task automatic apply_stimulus(input int pulses);
        repeat (pulses) begin
            set_min = 1'b1;
            step(4);
            set_min = 1'b0;
            step(4);
        end
    endtask

    initial begin
        int carries;
        int carry_edge;
        int dbl_tick;
        int sec_wraps;
        int min_changes;
        logic prev_tick;
        logic [7:0] prev_min;

        reset = 1'b0; run = 1'b1; set_min = 1'b0; clr_sec = 1'b0;
        #23;
        check_output("reset_digits", {min_bcd(), sec_bcd()}, 16'h0000);
        check_output("reset_strobes", {14'd0, tick_1hz, hour_carry}, 16'h0000);
        #4 reset = 1'b1;

        step(3);
        check_output("tick_before_first_second", {15'd0, tick_1hz}, 16'd0);
        step(1);
        check_output("sec_after_4", {8'h00, sec_bcd()}, 16'h0001);
        check_output("tick_first_second", {15'd0, tick_1hz}, 16'd1);
        step(1);
        check_output("tick_one_cycle", {15'd0, tick_1hz}, 16'd0);
        step(35);
        check_output("sec_after_40", {8'h00, sec_bcd()}, 16'h0010);

        carries = 0; carry_edge = 0; dbl_tick = 0; sec_wraps = 0; min_changes = 0;
        prev_tick = tick_1hz; prev_min = min_bcd(); carry_seen = 0;
        for (int n = 41; n <= 14400; n++) begin
            step(1);
            if (hour_carry) begin
                carries++;
                carry_edge = n;
            end
            if (prev_tick && tick_1hz) dbl_tick++;
            if (tick_1hz && sec_bcd() == 8'h00) sec_wraps++;
            if (n < 14400 && min_bcd() != prev_min) min_changes++;
            if (n == 14399) check_output("time_before_rollover", {min_bcd(), sec_bcd()}, 16'h5959);
            prev_tick = tick_1hz;
            prev_min  = min_bcd();
        end
        check_output("time_after_hour", {min_bcd(), sec_bcd()}, 16'h0000);
        check_output("hour_carry_count", carries[15:0], 16'd1);
        check_output("hour_carry_edge", carry_edge[15:0], 16'd14400);
        check_output("tick_never_double", dbl_tick[15:0], 16'd0);
        check_output("sec_wraps_per_hour", sec_wraps[15:0], 16'd60);
        check_output("min_changes_before_carry", min_changes[15:0], 16'd59);
        step(1);
        check_output("hour_carry_one_cycle", {15'd0, hour_carry}, 16'd0);

        run = 1'b0;
        step(4);
        check_output("stopped_holds", {min_bcd(), sec_bcd()}, 16'h0000);
        carry_seen = 0;
        apply_stimulus(58);
        check_output("set_to_58", {min_bcd(), sec_bcd()}, 16'h5800);
        set_min = 1'b1;
        step(2);
        check_output("set_latency_2_edges", {8'h00, min_bcd()}, 16'h0058);
        step(1);
        check_output("set_latency_3_edges", {8'h00, min_bcd()}, 16'h0059);
        step(1);
        set_min = 1'b0;
        step(4);
        apply_stimulus(1);
        check_output("set_wrap_to_00", {8'h00, min_bcd()}, 16'h0000);
        apply_stimulus(1);
        check_output("set_to_01", {min_bcd(), sec_bcd()}, 16'h0100);
        check_output("set_no_hour_carry", carry_seen[15:0], 16'd0);

        run = 1'b1;
        set_min = 1'b1;
        step(4);
        run = 1'b0;
        step(4);
        check_output("set_ignored_while_run", {8'h00, min_bcd()}, 16'h0001);
        set_min = 1'b0;
        step(4);
        check_output("no_stale_set", {8'h00, min_bcd()}, 16'h0001);

        run = 1'b1;
        clr_sec = 1'b1;
        step(1);
        clr_sec = 1'b0;
        check_output("clr_zeroes_sec", {8'h00, sec_bcd()}, 16'h0000);
        step(148);
        check_output("count_to_37", {min_bcd(), sec_bcd()}, 16'h0137);
        clr_sec = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1);
            check_output("clr_hold", {7'd0, tick_1hz, sec_bcd()}, 16'h0000);
        end
        clr_sec = 1'b0;
        check_output("clr_keeps_min", {8'h00, min_bcd()}, 16'h0001);
        step(3);
        check_output("no_tick_before_4", {7'd0, tick_1hz, sec_bcd()}, 16'h0000);
        step(1);
        check_output("tick_4_after_clr", {7'd0, tick_1hz, sec_bcd()}, 16'h0101);

        run = 1'b0;
        apply_stimulus(11);
        clr_sec = 1'b1;
        step(1);
        clr_sec = 1'b0;
        run = 1'b1;
        step(136);
        check_output("reach_12_34", {min_bcd(), sec_bcd()}, 16'h1234);
        step(2);
        set_min = 1'b1;
        step(3);
        reset = 1'b0;
        #1;
        check_output("async_reset_digits", {min_bcd(), sec_bcd()}, 16'h0000);
        check_output("async_reset_strobes", {14'd0, tick_1hz, hour_carry}, 16'h0000);
        run = 1'b0;
        step(2);
        reset = 1'b1;
        carry_seen = 0;
        step(6);
        check_output("held_button_no_inc", {min_bcd(), sec_bcd()}, 16'h0000);
        set_min = 1'b0;
        step(4);
        check_output("button_release_no_inc", {8'h00, min_bcd()}, 16'h0000);
        set_min = 1'b1;
        step(4);
        check_output("fresh_press_inc", {8'h00, min_bcd()}, 16'h0001);
        check_output("no_carry_after_reset", carry_seen[15:0], 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/maq_ms.md
Name: maq_ms

Overview:
- Upstream stage of the hours counter.
- Divides the system clock down to 1 Hz and keeps seconds and minutes as BCD digit pairs, each counting 00..59.
- Emits a registered one-cycle hour-carry strobe on each 59:59 -> 00:00 rollover; the hours stage consumes this strobe.
- Provides a manual minute-set input, honoured only while stopped, and a seconds-clear input.

Parameters:
- CLK_HZ, 50_000_000, input clock cycles per second. Must be >= 2. The bench uses 4.
- PRE_W, $clog2(CLK_HZ), prescaler width. Derived; not overridden.

Ports:
- maq_ms_clock  input  1  system clock; all logic on rising edge.
- maq_ms_reset  input  1  asynchronous active-low reset.
- maq_ms_run  input  1  1 = counting, 0 = stopped (set mode).
- maq_ms_set_min  input  1  asynchronous push button; each rising edge adds one minute while stopped.
- maq_ms_clr_sec  input  1  synchronous level input; clears seconds and prescaler.
- maq_ms_sec_lsd  output  4  seconds units digit, 0..9.
- maq_ms_sec_msd  output  3  seconds tens digit, 0..5.
- maq_ms_min_lsd  output  4  minutes units digit, 0..9.
- maq_ms_min_msd  output  3  minutes tens digit, 0..5.
- maq_ms_tick_1hz  output  1  one-cycle pulse on each seconds advance.
- maq_ms_hour_carry  output  1  one-cycle pulse on 59:59 -> 00:00 rollover.

Behaviour:
- Reset (maq_ms_reset=0, asynchronous):
  - All digits, prescaler, maq_ms_tick_1hz and maq_ms_hour_carry go to 0.
  - Both set_min synchronizer flops and the edge-detect history flop go to 1, so a button held through reset release produces no increment.
  - Reset asserted mid-count discards all state; no carry is emitted.
- Prescaler:
  - Counts 0..CLK_HZ-1 while run=1 and clr_sec=0.
  - Holds its value while run=0.
  - Internal tick = (pre == CLK_HZ-1) && run && !clr_sec. On the tick edge the prescaler returns to 0.
- Seconds:
  - Advance by 1 on the tick edge.
  - lsd 9 -> 0 carries into msd; 59 -> 00 carries into minutes.
- Minutes:
  - Advance by 1 on a seconds carry; 59 -> 00 raises the hour-carry condition.
- Outputs:
  - maq_ms_tick_1hz is registered and high for exactly the one cycle in which the new seconds value is visible.
  - maq_ms_hour_carry is registered and high for exactly the one cycle in which the outputs first show 00:00 after 59:59.
  - Neither strobe is ever high for more than one cycle.
- clr_sec:
  - Level-sensitive and synchronous; has priority over the tick.
  - Each cycle it is high, seconds go to 00 and the prescaler goes to 0.
  - Minutes are untouched, and no tick or carry is produced that cycle.
- set_min:
  - Passes through a 2-flop synchronizer, then rising-edge detection.
  - When an edge is detected and run=0: minutes += 1 mod 60. Seconds are unchanged, and no hour carry is produced, including on the 59 -> 00 wrap.
  - Edges seen while run=1 are discarded; they are not queued.
  - Latency: the minute update is visible 3 clock edges after the button input rises.
- Simultaneous events:
  - run=0 rules out a tick and an accepted set edge in the same cycle.
  - clr_sec together with a set edge: both take effect in that cycle.
- Arithmetic:
  - Digits never take illegal values: lsd stays in 0..9 and msd in 0..5.
  - Out-of-range states cannot be reached from reset.

Decomposition:
- Package maq_pkg holds:
  - typedef bcd_t (logic [3:0]) and bcd6_t (logic [2:0]);
  - constants BCD_LSD_MAX=9 and BCD6_MSD_MAX=5.
- Sub-module maq_bcd60, instantiated twice (seconds and minutes):
  - inputs: clock, reset, inc, clr;
  - outputs: lsd, msd, wrap;
  - wrap is combinational and means inc is high while the count is 59.
- The top level holds the prescaler, the synchronizer, the edge detect, and the strobe registers.

Test Plan:
- CLK_HZ=4, run=1 from reset: after 4 clocks sec=01 and tick_1hz is high for 1 cycle; after 40 clocks sec=10 (sec_msd=1, sec_lsd=0).
- Run from 00:00 for 3600*4 clocks: min/sec = 00:00, and hour_carry pulses exactly once, coincident with 00:00; 59 tick-driven minute wraps occur before it.
- run=0, three set_min pulses (each 4 clocks high, 4 low) starting from 58:xx: minutes go 59, 00, 01; seconds stay constant; hour_carry stays 0.
- run=1 with set_min pulses: minutes are unchanged; after run drops, no stale increment appears.
- At sec=37, assert clr_sec for 5 cycles: sec=00 and the prescaler is 0; no tick during the assertion; the next tick comes 4 clocks after release.
- Assert reset at 12:34 mid-prescale, with set_min held high across reset release: all outputs are 0; no minute increment occurs after release until set_min falls and rises again.
